// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: stimulus generator for a/b/c and d/e sequence monitors.
// Latency: first a/d is high one cycle after start is accepted; all outputs are registered.
// Backpressure: none. start is ignored while busy; abort cancels a run immediately.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, abort        run command (IDLE only) and cancel (any non-IDLE state)
//   abc_en, de_en       channel enables, captured when start is accepted
//   de_gap, repeat_n    d-to-e gap and iteration count, captured when start is accepted
//   a, b, c, d, e       registered sequence outputs
//   busy, done, err     run in progress, end-of-run pulse, rejected-start pulse
module seq_pattern_gen #(
  parameter int CNT_W    = 8,
  parameter int IDLE_CYC = 2,
  parameter int GAP_MIN  = 2,
  parameter int GAP_MAX  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             abc_en,
  input  logic             de_en,
  input  logic [2:0]       de_gap,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int             SP_W      = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam logic [SP_W-1:0] SP_LAST  = SP_W'(IDLE_CYC - 1);
  localparam bit             HAS_SPACE = (IDLE_CYC > 0);
  localparam logic [2:0]     GMIN      = 3'(GAP_MIN);
  localparam logic [2:0]     GMAX      = 3'(GAP_MAX);

  typedef enum logic [1:0] {IDLE, STEP, SPACE, FIN} state_t;

  state_t            state, state_n;
  logic [2:0]        s, s_n;
  logic [2:0]        last_s, last_s_n;
  logic [2:0]        gap_q, gap_n;
  logic              abc_q, abc_n;
  logic              de_q, de_n;
  logic [CNT_W-1:0]  iter, iter_n;
  logic [CNT_W-1:0]  rep_q, rep_n;
  logic [SP_W-1:0]   sp, sp_n;

  // Start-time configuration decode
  logic       cfg_bad;
  logic [2:0] len_abc, len_de, len_max;

  // Next values of the registered outputs
  logic a_n, b_n, c_n, d_n, e_n, busy_n, done_n, err_n;

  always_comb begin
    len_abc = abc_en ? 3'd3 : 3'd0;
    len_de  = de_en ? (de_gap + 3'd1) : 3'd0;
    len_max = (len_abc > len_de) ? len_abc : len_de;
    cfg_bad = (!abc_en && !de_en) ||
              (de_en && ((de_gap < GMIN) || (de_gap > GMAX)));
  end

  always_comb begin
    state_n  = state;
    s_n      = s;
    last_s_n = last_s;
    gap_n    = gap_q;
    abc_n    = abc_q;
    de_n     = de_q;
    iter_n   = iter;
    rep_n    = rep_q;
    sp_n     = sp;
    err_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_bad) begin
            err_n = 1'b1;
          end else begin
            abc_n    = abc_en;
            de_n     = de_en;
            gap_n    = de_gap;
            rep_n    = repeat_n;
            last_s_n = len_max - 3'd1;
            s_n      = 3'd0;
            iter_n   = '0;
            state_n  = (repeat_n == '0) ? FIN : STEP;
          end
        end
      end
      STEP: begin
        if (s == last_s) begin
          // rep_q >= 1 in STEP, so rep_q-1 never wraps and the full count range runs
          if (iter == rep_q - CNT_W'(1)) begin
            state_n = FIN;
          end else begin
            iter_n = iter + CNT_W'(1);
            s_n    = 3'd0;
            if (HAS_SPACE) begin
              state_n = SPACE;
              sp_n    = '0;
            end else begin
              state_n = STEP;
            end
          end
        end else begin
          s_n = s + 3'd1;
        end
      end
      SPACE: begin
        if (sp == SP_LAST) begin
          state_n = STEP;
          s_n     = 3'd0;
        end else begin
          sp_n = sp + SP_W'(1);
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (abort && (state != IDLE)) begin
      state_n = IDLE;
    end
  end

  // Outputs are decoded from the state being entered so they appear one cycle after it
  always_comb begin
    a_n    = (state_n == STEP) && abc_n && (s_n == 3'd0);
    b_n    = (state_n == STEP) && abc_n && (s_n == 3'd1);
    c_n    = (state_n == STEP) && abc_n && (s_n == 3'd2);
    d_n    = (state_n == STEP) && de_n  && (s_n == 3'd0);
    e_n    = (state_n == STEP) && de_n  && (s_n == gap_n);
    busy_n = (state_n == STEP) || (state_n == SPACE);
    done_n = (state_n == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      s      <= 3'd0;
      last_s <= 3'd0;
      gap_q  <= 3'd0;
      abc_q  <= 1'b0;
      de_q   <= 1'b0;
      iter   <= '0;
      rep_q  <= '0;
      sp     <= '0;
      a      <= 1'b0;
      b      <= 1'b0;
      c      <= 1'b0;
      d      <= 1'b0;
      e      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      s      <= s_n;
      last_s <= last_s_n;
      gap_q  <= gap_n;
      abc_q  <= abc_n;
      de_q   <= de_n;
      iter   <= iter_n;
      rep_q  <= rep_n;
      sp     <= sp_n;
      a      <= a_n;
      b      <= b_n;
      c      <= c_n;
      d      <= d_n;
      e      <= e_n;
      busy   <= busy_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed table-driven bench for seq_pattern_gen.
// Rows give inputs for one cycle and the {a,b,c,d,e,busy,done,err} expected the next cycle.
// A second instance built with IDLE_CYC=0 covers back-to-back and full-count runs.
module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       rst, start, start0, abort, abc_en, de_en;
  logic [2:0] de_gap;
  logic [7:0] repeat_n;

  logic a, b, c, d, e, busy, done, err;
  logic a0, b0, c0, d0, e0, busy0, done0, err0;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seq_pattern_gen #(.CNT_W(8), .IDLE_CYC(2), .GAP_MIN(2), .GAP_MAX(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .abc_en(abc_en),
    .de_en(de_en), .de_gap(de_gap), .repeat_n(repeat_n),
    .a(a), .b(b), .c(c), .d(d), .e(e), .busy(busy), .done(done), .err(err)
  );

  seq_pattern_gen #(.CNT_W(8), .IDLE_CYC(0), .GAP_MIN(2), .GAP_MAX(5)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort), .abc_en(abc_en),
    .de_en(de_en), .de_gap(de_gap), .repeat_n(repeat_n),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .busy(busy0), .done(done0), .err(err0)
  );

  // Expected output codes, bit order {a,b,c,d,e,busy,done,err}
  localparam logic [7:0] Z    = 8'b0000_0000;
  localparam logic [7:0] BUSY = 8'b0000_0100;
  localparam logic [7:0] DONE = 8'b0000_0010;
  localparam logic [7:0] ERR  = 8'b0000_0001;
  localparam logic [7:0] AD   = 8'b1001_0100;
  localparam logic [7:0] AA   = 8'b1000_0100;
  localparam logic [7:0] DD   = 8'b0001_0100;
  localparam logic [7:0] BB   = 8'b0100_0100;
  localparam logic [7:0] CC   = 8'b0010_0100;
  localparam logic [7:0] EE   = 8'b0000_1100;

  typedef struct {
    logic       rst;
    logic       start;
    logic       abort;
    logic       abc;
    logic       de;
    logic [2:0] gap;
    logic [7:0] rep;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic st, input logic ab, input logic ac,
                     input logic dn, input logic [2:0] g, input logic [7:0] rp,
                     input logic [7:0] ex);
    vec_t v;
    v.rst = r; v.start = st; v.abort = ab; v.abc = ac; v.de = dn;
    v.gap = g; v.rep = rp; v.exp = ex;
    tbl.push_back(v);
  endtask

  task automatic idle(input logic [7:0] ex);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, ex);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] outv();
    return {a, b, c, d, e, busy, done, err};
  endfunction

  function automatic logic [7:0] outv0();
    return {a0, b0, c0, d0, e0, busy0, done0, err0};
  endfunction

  initial begin
    // Basic run, both channels, gap 3, two iterations
    add(0, 1, 0, 1, 1, 3'd3, 8'd2, AD);
    idle(BB); idle(CC); idle(EE); idle(BUSY); idle(BUSY);
    idle(AD); idle(BB); idle(CC); idle(EE); idle(DONE); idle(Z);
    // Gap sweep, d/e only
    add(0, 1, 0, 0, 1, 3'd2, 8'd1, DD);
    idle(BUSY); idle(EE); idle(DONE); idle(Z);
    add(0, 1, 0, 0, 1, 3'd5, 8'd1, DD);
    idle(BUSY); idle(BUSY); idle(BUSY); idle(BUSY); idle(EE); idle(DONE); idle(Z);
    // Illegal configurations
    add(0, 1, 0, 0, 1, 3'd1, 8'd1, ERR); idle(Z);
    add(0, 1, 0, 0, 0, 3'd3, 8'd1, ERR); idle(Z);
    add(0, 1, 0, 1, 1, 3'd6, 8'd1, ERR); idle(Z);
    // Zero iterations
    add(0, 1, 0, 1, 0, 3'd3, 8'd0, DONE); idle(Z);
    // abort+start in IDLE, abort alone in IDLE
    add(0, 1, 1, 1, 1, 3'd3, 8'd1, Z); idle(Z);
    add(0, 0, 1, 0, 0, 3'd0, 8'd0, Z);
    // start while busy (with an otherwise illegal config) is ignored
    add(0, 1, 0, 1, 0, 3'd3, 8'd1, AA);
    add(0, 1, 0, 0, 0, 3'd3, 8'd1, BB);
    idle(CC); idle(DONE); idle(Z);
    // Abort during the spacing after the second iteration of five
    add(0, 1, 0, 1, 1, 3'd3, 8'd5, AD);
    idle(BB); idle(CC); idle(EE); idle(BUSY); idle(BUSY);
    idle(AD); idle(BB); idle(CC); idle(EE); idle(BUSY);
    add(0, 0, 1, 0, 0, 3'd0, 8'd0, Z);
    idle(Z); idle(Z); idle(Z);
    add(0, 1, 0, 1, 1, 3'd3, 8'd1, AD);
    idle(BB); idle(CC); idle(EE); idle(DONE); idle(Z);
    // Reset mid-STEP overrides a simultaneous start; fresh run afterwards
    add(0, 1, 0, 1, 1, 3'd3, 8'd2, AD);
    idle(BB);
    add(1, 1, 0, 1, 1, 3'd3, 8'd2, Z);
    idle(Z);
    add(0, 1, 0, 1, 0, 3'd3, 8'd1, AA);
    idle(BB); idle(CC); idle(DONE); idle(Z);
  end

  initial begin
    int na, nc, dc;
    rst = 1'b1; start = 1'b0; start0 = 1'b0; abort = 1'b0;
    abc_en = 1'b0; de_en = 1'b0; de_gap = 3'd0; repeat_n = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", outv(), Z);
    chk("reset_b2b", outv0(), Z);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort;
      abc_en = tbl[i].abc; de_en = tbl[i].de; de_gap = tbl[i].gap;
      repeat_n = tbl[i].rep;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), outv(), tbl[i].exp);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;

    // Back-to-back build: abc only, three iterations, no spacing
    abc_en = 1'b1; de_en = 1'b0; de_gap = 3'd3; repeat_n = 8'd3; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      logic [7:0] ex;
      ex = Z;
      ex[7] = (k == 1) || (k == 4) || (k == 7);
      ex[6] = (k == 2) || (k == 5) || (k == 8);
      ex[5] = (k == 3) || (k == 6) || (k == 9);
      ex[2] = (k <= 9);
      ex[1] = (k == 10);
      chk($sformatf("b2b_c%0d", k), outv0(), ex);
      @(posedge clk);
      #1;
    end

    // Full-count run: 255 iterations must not wrap
    repeat_n = 8'd255; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    na = 0; nc = 0; dc = -1;
    for (int k = 1; k <= 1000 && dc < 0; k++) begin
      if (a0) na++;
      if (c0) nc++;
      if (done0) dc = k;
      @(posedge clk);
      #1;
    end
    chk_int("full_a_count", na, 255);
    chk_int("full_c_count", nc, 255);
    chk_int("full_done_cycle", dc, 766);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Synthesizable stimulus generator. It is the driving end of the a/b/c and d/e sequence checks used in the SystemVerilog tests.
- On a start command it emits `a ##1 b ##1 c` and `d ##[gap] e` (gap programmable 2..5), repeated N times with fixed idle spacing.
- Feeds sequence/assertion monitors so `.triggered`-style detectors can be exercised deterministically.

Parameters:
- CNT_W, 8, width of the repeat count input and the internal iteration counter.
- IDLE_CYC, 2, all-zero cycles inserted between consecutive iterations (0 allowed = back-to-back).
- GAP_MIN, 2, smallest legal d-to-e gap in cycles.
- GAP_MAX, 5, largest legal d-to-e gap in cycles.

Ports:
- clk  input  1  single clock; everything sampled and updated on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle command; sampled only when busy=0.
- abort  input  1  synchronous cancel of the current run.
- abc_en  input  1  enable a/b/c sequence generation.
- de_en  input  1  enable d/e sequence generation.
- de_gap  input  3  cycles from d to e; legal GAP_MIN..GAP_MAX.
- repeat_n  input  CNT_W  number of iterations.
- a, b, c  output  1 each  registered sequence outputs.
- d, e  output  1 each  registered sequence outputs.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse after the final iteration completes.
- err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0. Reset overrides abort and start.
- FSM states: IDLE, STEP, SPACE, FIN.

IDLE
- On start=1 with abort=0, the block latches abc_en, de_en, de_gap and repeat_n.
- Rejected start, producing err=1 the next cycle and staying in IDLE:
  - abc_en=0 and de_en=0, or
  - de_en=1 with de_gap outside GAP_MIN..GAP_MAX.
- repeat_n=0: go to FIN, so done pulses the next cycle with no sequence output.
- Otherwise go to STEP with step=0 and iter=0.

STEP
- Iteration length L = max(abc_en ? 3 : 0, de_en ? de_gap+1 : 0).
- Step counter s runs 0..L-1, one value per cycle.
- Registered outputs, computed from the state being entered so they appear the cycle after the transition:
  - a = abc_en & (s==0)
  - b = abc_en & (s==1)
  - c = abc_en & (s==2)
  - d = de_en & (s==0)
  - e = de_en & (s==de_gap)
- Disabled channels stay 0.
- At s==L-1, iter increments:
  - If iter+1==repeat_n, go to FIN.
  - Else go to SPACE if IDLE_CYC>0, or directly back to STEP s=0 if IDLE_CYC=0.

SPACE
- Lasts exactly IDLE_CYC cycles; all a..e are 0; then STEP s=0.
- No spacing is inserted after the final iteration.

FIN
- done=1 for exactly one cycle, then IDLE.

Latency and handshake
- First a/d is high the cycle after start is accepted.
- busy is high from that cycle through the last STEP cycle inclusive, including SPACE cycles.
- busy is 0 in the done cycle and in IDLE.
- start while busy=1 is ignored and produces no err.
- Config inputs are don't-care except in the start-accept cycle.

Abort
- abort=1 in any state except IDLE: next cycle is IDLE with a..e=0 and busy=0; no done, no err.
- abort in IDLE is a no-op.
- abort and start in the same cycle: abort wins and start is dropped.

Counting
- The iteration counter is CNT_W wide; repeat_n up to 2^CNT_W-1 must run fully without wrap.
- The step counter is 3 bits (L ≤ 6).

Test Plan:
- Basic, both channels: abc_en=1, de_en=1, de_gap=3, repeat_n=2, IDLE_CYC=2, start at cycle 0.
  - Expected: a,d@1; b@2; c@3; e@4; zeros@5–6; a,d@7; b@8; c@9; e@10; done@11 only; busy high 1..10.
- Gap sweep: de_only, de_gap=2, then 5, repeat_n=1.
  - Expected: d@1 with e@3 (L=3); then d@1 with e@6 (L=6); a/b/c stay 0; done the cycle after e.
- Illegal config:
  - start with de_en=1, de_gap=1 → err@1, busy 0, no outputs.
  - start with both enables 0 → err@1.
  - start with de_gap=6 → err@1.
- Zero and back-to-back: repeat_n=0 → done@1, no outputs. Then IDLE_CYC=0 build, abc only, repeat_n=3 → a@1,4,7; c@3,6,9; done@10.
- Abort mid-run: start repeat_n=5, assert abort during the SPACE of iteration 2 → all outputs 0 and busy 0 the next cycle, no done. A following start runs a full fresh sequence.
- Contention:
  - start while busy → ignored.
  - abort+start together in IDLE → nothing happens.
  - rst asserted mid-STEP → next cycle all outputs 0, IDLE, and a new start is accepted afterwards.
